// File: rtl/uart_fifo_pkg.sv
// Shared types and baud helper for the UART FIFO core.
package uart_fifo_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_fifo_core_fifo.sv
// Synchronous first-word-fall-through FIFO with pointer-plus-count flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// 8N1-style UART: TX FIFO -> serializer, deserializer -> RX FIFO.
module uart_fifo_core
    import uart_fifo_pkg::*;
#(
    parameter int CLK_HZ       = 25000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    output logic                    uart_txd,
    input  logic                    tx_push,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    tx_full,
    output logic                    tx_empty,
    output logic                    tx_busy,
    input  logic                    rx_pop,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_empty,
    output logic                    rx_full,
    output logic                    rx_break,
    output logic                    rx_frame_err,
    output logic                    rx_overrun
);
    localparam int CPB     = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CNT_W   = $clog2(CPB + 1);
    localparam int BIT_MAX = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);

    logic [PAYLOAD_BITS-1:0] tx_head;
    logic                    tx_pop;
    logic                    rx_push;

    tx_state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]        tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]        tx_bit, tx_bit_n;
    logic [PAYLOAD_BITS-1:0] tx_shift, tx_shift_n;
    logic                    txd_n;

    rx_state_t               rx_state, rx_state_n;
    logic [CNT_W-1:0]        rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]        rx_bit, rx_bit_n;
    logic [PAYLOAD_BITS-1:0] rx_shift, rx_shift_n;
    logic                    rx_sync1, rx_sync2;
    logic                    break_n, frame_err_n, overrun_n;

    sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .wr_data(tx_data), .pop(tx_pop),
        .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .wr_data(rx_shift), .pop(rx_pop),
        .rd_data(rx_data), .full(rx_full), .empty(rx_empty)
    );

    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_txd <= txd_n;
        end
    end

    // The last stop cycle reloads directly so back-to-back frames have no idle gap.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_shift_n = tx_head;
                    tx_pop     = 1'b1;
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                tx_cnt_n = tx_cnt + CNT_W'(1);
                if (tx_cnt == CNT_W'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_cnt_n = tx_cnt + CNT_W'(1);
                if (tx_cnt == CNT_W'(CPB - 1)) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    tx_bit_n   = tx_bit + BIT_W'(1);
                    if (tx_bit == BIT_W'(PAYLOAD_BITS - 1)) begin
                        tx_bit_n   = '0;
                        tx_state_n = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                tx_cnt_n = tx_cnt + CNT_W'(1);
                if (tx_cnt == CNT_W'(CPB - 1)) begin
                    tx_cnt_n = '0;
                    tx_bit_n = tx_bit + BIT_W'(1);
                    if (tx_bit == BIT_W'(STOP_BITS - 1)) begin
                        tx_bit_n   = '0;
                        tx_state_n = TX_IDLE;
                        if (!tx_empty) begin
                            tx_shift_n = tx_head;
                            tx_pop     = 1'b1;
                            tx_state_n = TX_START;
                        end
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        txd_n = 1'b1;
        if (tx_state_n == TX_START) begin
            txd_n = 1'b0;
        end else if (tx_state_n == TX_DATA) begin
            txd_n = tx_shift_n[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1     <= 1'b1;
            rx_sync2     <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_break     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_sync1     <= uart_rxd;
            rx_sync2     <= rx_sync1;
            rx_state     <= rx_state_n;
            rx_cnt       <= rx_cnt_n;
            rx_bit       <= rx_bit_n;
            rx_shift     <= rx_shift_n;
            rx_break     <= break_n;
            rx_frame_err <= frame_err_n;
            rx_overrun   <= overrun_n;
        end
    end

    // Half a bit after the falling edge confirms the start bit; later samples land mid-bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        break_n     = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync2) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                rx_cnt_n = rx_cnt + CNT_W'(1);
                if (rx_cnt == CNT_W'(CPB / 2 - 1)) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_n = rx_cnt + CNT_W'(1);
                if (rx_cnt == CNT_W'(CPB - 1)) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync2, rx_shift[PAYLOAD_BITS-1:1]};
                    rx_bit_n   = rx_bit + BIT_W'(1);
                    if (rx_bit == BIT_W'(PAYLOAD_BITS - 1)) begin
                        rx_bit_n   = '0;
                        rx_state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                rx_cnt_n = rx_cnt + CNT_W'(1);
                if (rx_cnt == CNT_W'(CPB - 1)) begin
                    rx_cnt_n = '0;
                    if (rx_sync2) begin
                        rx_state_n = RX_IDLE;
                        if (rx_full && !rx_pop) begin
                            overrun_n = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end else begin
                        rx_state_n = RX_WAIT_HIGH;
                        if (rx_shift == '0) begin
                            break_n = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                        end
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync2) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at 10 clock cycles per bit.
module tb_uart_fifo_core;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } tx_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       uart_txd;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       tx_full, tx_empty, tx_busy;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_empty, rx_full;
    logic       rx_break, rx_frame_err, rx_overrun;

    logic       loopback;
    logic       rxd_drv;
    int         checks = 0;
    int         errors = 0;
    int         brk_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
    int         brk0, ferr0, ovr0;
    int         good, busy;
    tx_vec_t    vecs[3];

    assign uart_rxd = loopback ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart_fifo_core #(
        .CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .tx_busy(tx_busy), .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_break(rx_break), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun)
    );

    always @(negedge clk) begin
        if (rx_break) brk_cnt++;
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        tx_push = 1'b1;
        tx_data = d;
        tick(1);
        tx_push = 1'b0;
    endtask

    task automatic popCheck(input string name, input logic [7:0] expected);
        checkOutput(name, rx_data, expected);
        rx_pop = 1'b1;
        tick(1);
        rx_pop = 1'b0;
    endtask

    task automatic waitTxIdle(input int budget);
        int n = 0;
        while ((tx_busy || !tx_empty) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("tx idle within budget", (tx_busy || !tx_empty) ? 0 : 1, 1);
    endtask

    task automatic sendSerial(input logic [7:0] d, input logic stop);
        rxd_drv = 1'b0;
        tick(10);
        for (int b = 0; b < 8; b++) begin
            rxd_drv = d[b];
            tick(10);
        end
        rxd_drv = stop;
        tick(10);
        rxd_drv = 1'b1;
        tick(20);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h01, frame: 10'h202};
        vecs[2] = '{data: 8'h80, frame: 10'h300};

        reset    = 1'b1;
        loopback = 1'b0;
        rxd_drv  = 1'b1;
        tx_push  = 1'b0;
        tx_data  = 8'h00;
        rx_pop   = 1'b0;
        tick(3);
        reset = 1'b0;

        brk0 = brk_cnt; ferr0 = ferr_cnt; ovr0 = ovr_cnt;
        tick(50);
        checkOutput("reset txd", uart_txd, 1);
        checkOutput("reset tx_empty", tx_empty, 1);
        checkOutput("reset rx_empty", rx_empty, 1);
        checkOutput("reset tx_full", tx_full, 0);
        checkOutput("reset rx_full", rx_full, 0);
        checkOutput("reset tx_busy", tx_busy, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset pulses", (brk_cnt - brk0) + (ferr_cnt - ferr0) + (ovr_cnt - ovr0), 0);

        loopback = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].data);
            checkOutput($sformatf("tx_empty after push %02h", vecs[i].data), tx_empty, 0);
            tick(1);
            busy = 0;
            for (int k = 0; k < 10; k++) begin
                good = 0;
                for (int c = 0; c < 10; c++) begin
                    if (uart_txd === vecs[i].frame[k]) good++;
                    if (tx_busy) busy++;
                    tick(1);
                end
                checkOutput($sformatf("frame %02h bit %0d cycles", vecs[i].data, k), good, 10);
            end
            checkOutput($sformatf("tx_busy cycles %02h", vecs[i].data), busy, 100);
            checkOutput("tx_busy after frame", tx_busy, 0);
            checkOutput("txd idle after frame", uart_txd, 1);
            checkOutput("tx_empty after frame", tx_empty, 1);
            checkOutput("loopback rx_empty", rx_empty, 0);
            popCheck($sformatf("loopback rx_data %02h", vecs[i].data), vecs[i].data);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i));
        end
        waitTxIdle(1500);
        tick(5);
        checkOutput("rx_full after 8 frames", rx_full, 1);

        ovr0 = ovr_cnt;
        applyStimulus(8'h3C);
        waitTxIdle(300);
        tick(5);
        checkOutput("overrun pulses", ovr_cnt - ovr0, 1);
        checkOutput("rx_full after overrun", rx_full, 1);
        for (int i = 0; i < 8; i++) begin
            popCheck($sformatf("pop order %0d", i), 8'(i));
        end
        checkOutput("rx_empty after drain", rx_empty, 1);
        loopback = 1'b0;

        brk0 = brk_cnt; ferr0 = ferr_cnt;
        rxd_drv = 1'b0;
        tick(120);
        rxd_drv = 1'b1;
        tick(200);
        checkOutput("break pulses", brk_cnt - brk0, 1);
        checkOutput("break frame_err", ferr_cnt - ferr0, 0);
        checkOutput("break rx_empty", rx_empty, 1);

        brk0 = brk_cnt; ferr0 = ferr_cnt;
        sendSerial(8'h5A, 1'b0);
        checkOutput("frame_err pulses", ferr_cnt - ferr0, 1);
        checkOutput("frame_err break", brk_cnt - brk0, 0);
        checkOutput("frame_err rx_empty", rx_empty, 1);
        sendSerial(8'hC3, 1'b1);
        popCheck("serial rx_data", 8'hC3);

        brk0 = brk_cnt; ferr0 = ferr_cnt; ovr0 = ovr_cnt;
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(150);
        checkOutput("glitch pulses", (brk_cnt - brk0) + (ferr_cnt - ferr0) + (ovr_cnt - ovr0), 0);
        checkOutput("glitch rx_empty", rx_empty, 1);

        applyStimulus(8'h55);
        applyStimulus(8'h66);
        tick(30);
        checkOutput("mid-frame txd low-capable busy", tx_busy, 1);
        reset = 1'b1;
        tick(1);
        checkOutput("reset mid-frame txd", uart_txd, 1);
        checkOutput("reset mid-frame tx_empty", tx_empty, 1);
        checkOutput("reset mid-frame tx_busy", tx_busy, 0);
        reset = 1'b0;
        tick(20);
        checkOutput("post-reset txd", uart_txd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
